// File: rtl/divider_pkg.sv
// Shared types and defaults for the serial restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_divider_8_bits_controller_if.sv
// START/DONE request-response bundle between a requester and the serial divider.
interface serial_divider_8_bits_controller_if #(
    parameter int unsigned WIDTH = divider_pkg::DIV_WIDTH_DEFAULT
) ();

    logic             START;
    logic [WIDTH-1:0] DIVIDEND;
    logic [WIDTH-1:0] DIVISOR;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             DIV_BY_ZERO;

    modport master (
        output START, DIVIDEND, DIVISOR,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );

    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );

endinterface

// File: rtl/borrow_ripple_subtractor.sv
// Combinational ripple-borrow subtractor built from 1-bit full-subtractor cells.
module borrow_ripple_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
);

    logic [WIDTH:0] borrow;

    assign borrow[0] = bin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff_o[i]   = a_i[i] ^ b_i[i] ^ borrow[i];
        assign borrow[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
    end

    assign bout_o = borrow[WIDTH];

endmodule

// File: rtl/serial_divider_8_bits_controller.sv
// Unsigned restoring divider, one trial subtraction per clock.
// Optional DIVIDER_FAST_ZERO_EN: a zero divisor skips the iterations and finishes in one cycle.
module serial_divider_8_bits_controller
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    serial_divider_8_bits_controller_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             success;
    logic [WIDTH-1:0] iter_q;
    logic [WIDTH-1:0] iter_r;
    logic             last_iter;
    logic             zero_div;

    // Shift-in of the next dividend bit and the single shared trial subtraction
    assign shifted = {r_q, q_q[WIDTH-1]};

    borrow_ripple_subtractor #(.WIDTH(WIDTH)) u_sub (
        .a_i    (shifted[WIDTH-1:0]),
        .b_i    (d_q),
        .bin_i  (1'b0),
        .diff_o (diff),
        .bout_o (bout)
    );

    // A set bit above the window means the partial remainder already exceeds D
    assign success   = shifted[WIDTH] | ~bout;
    assign iter_q    = {q_q[WIDTH-2:0], success};
    assign iter_r    = success ? diff : shifted[WIDTH-1:0];
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign zero_div  = (bus.DIVISOR == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
`ifdef DIVIDER_FAST_ZERO_EN
                    state_d = zero_div ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    q_d   = bus.DIVIDEND;
                    r_d   = '0;
                    d_d   = bus.DIVISOR;
                    cnt_d = '0;
                    dbz_d = zero_div;
`ifdef DIVIDER_FAST_ZERO_EN
                    if (zero_div) begin
                        quo_d = '1;
                        rem_d = bus.DIVIDEND;
                    end
`endif
                end
            end
            CALC: begin
                q_d   = iter_q;
                r_d   = iter_r;
                cnt_d = cnt_q + CNT_W'(1);
                // Results are published only on the final iteration
                if (last_iter) begin
                    quo_d = iter_q;
                    rem_d = iter_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.QUOTIENT    = quo_q;
    assign bus.REMAINDER   = rem_q;
    assign bus.DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_serial_divider_8_bits_controller.sv
// Scoreboard bench for the serial divider: driver queues expected results, monitor checks on DONE.
module tb_serial_divider_8_bits_controller;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    bit   prev_done;

    serial_divider_8_bits_controller_if #(.WIDTH(8)) bus ();

    serial_divider_8_bits_controller #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every DONE against the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (bus.DONE === 1'b1) begin
            vectors++;
            if (prev_done) begin
                miscompares++;
                $display("FAIL done_width: DONE high on two consecutive cycles, expected one");
            end
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_done: DONE with no outstanding request");
            end else begin
                e = sb.pop_front();
                if ({bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO} !== {e.q, e.r, e.dbz}) begin
                    miscompares++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=%0b",
                             bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO, e.q, e.r, e.dbz);
                end
            end
        end
        prev_done = (bus.DONE === 1'b1);
    end

    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit poke);
        int   lat;
        int   exp_lat;
        bit   seen;
        exp_t e;
        e = model(a, b);
`ifdef DIVIDER_FAST_ZERO_EN
        exp_lat = (b == 8'd0) ? 1 : 9;
`else
        exp_lat = 9;
`endif
        @(negedge CLK);
        bus.START    = 1'b1;
        bus.DIVIDEND = a;
        bus.DIVISOR  = b;
        sb.push_back(e);
        @(negedge CLK);
        bus.START    = 1'b0;
        bus.DIVIDEND = 8'($urandom);
        bus.DIVISOR  = 8'($urandom);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 30) begin
            lat++;
            if (lat == 1) check("busy_after_accept", 32'(bus.BUSY), 32'd1);
            if (bus.DONE === 1'b1) begin
                seen = 1'b1;
            end else begin
                bus.START = poke && (lat == 3);
                @(negedge CLK);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_back());
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            bus.START = poke;
            @(negedge CLK);
            bus.START = 1'b0;
            check("busy_after_done", 32'(bus.BUSY), 32'd0);
            check("hold_quotient", 32'(bus.QUOTIENT), 32'(e.q));
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        prev_done    = 1'b0;
        RST_N        = 1'b1;
        bus.START    = 1'b0;
        bus.DIVIDEND = 8'd0;
        bus.DIVISOR  = 8'd0;
        #2 RST_N = 1'b0;
        #1;
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_done", 32'(bus.DONE), 32'd0);
        check("reset_quotient", 32'(bus.QUOTIENT), 32'd0);
        check("reset_remainder", 32'(bus.REMAINDER), 32'd0);
        check("reset_dbz", 32'(bus.DIV_BY_ZERO), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        do_div(8'd255, 8'd129, 1'b0);
        do_div(8'd130, 8'd200, 1'b0);
        do_div(8'd255, 8'd255, 1'b0);
        do_div(8'd255, 8'd1,   1'b0);
        do_div(8'd200, 8'd0,   1'b0);
        do_div(8'd10,  8'd3,   1'b0);
        do_div(8'd0,   8'd5,   1'b0);
        do_div(8'd100, 8'd9,   1'b1);
        repeat (3) @(negedge CLK);
        check("no_extra_done", 32'(sb.size()), 32'd0);

        // Asynchronous reset during the fourth iteration abandons the request
        @(negedge CLK);
        bus.START    = 1'b1;
        bus.DIVIDEND = 8'd200;
        bus.DIVISOR  = 8'd7;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midcalc_reset_busy", 32'(bus.BUSY), 32'd0);
        check("midcalc_reset_done", 32'(bus.DONE), 32'd0);
        check("midcalc_reset_quotient", 32'(bus.QUOTIENT), 32'd0);
        check("midcalc_reset_remainder", 32'(bus.REMAINDER), 32'd0);
        check("midcalc_reset_dbz", 32'(bus.DIV_BY_ZERO), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_div(8'd200, 8'd7, 1'b0);

        for (int n = 0; n < 2500; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = ($urandom_range(0, 49) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_div(a, b, ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
